// File: rtl/glbl_rst_seq_pkg.sv
// rtl/glbl_rst_seq_pkg.sv - state encoding and elaboration helpers for the global reset sequencer
package glbl_rst_seq_pkg;

   typedef enum logic [2:0] {
      HOLD      = 3'd0,
      WAIT_LOCK = 3'd1,
      ROC       = 3'd2,
      STAGE     = 3'd3,
      DONE      = 3'd4
   } state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << r) < 64'(v)) r = r + 1;
      end
      return r;
   endfunction

   // Largest value any sequencer or filter counter has to reach.
   function automatic int seq_cnt_max(input int roc, input int n_ch, input int gap, input int stable);
      int m;
      m = roc;
      if ((n_ch - 1) * gap > m) m = (n_ch - 1) * gap;
      if (stable > m) m = stable;
      return m;
   endfunction

endpackage

// File: rtl/glbl_rst_seq_lock_filter.sv
// rtl/glbl_rst_seq_lock_filter.sv - qualifies pll_locked over LOCK_STABLE consecutive cycles
module glbl_rst_seq_lock_filter
   import glbl_rst_seq_pkg::*;
#(
   parameter int LOCK_STABLE = 32,
   parameter int CNT_W       = 16
) (
   input  logic CLK,
   input  logic RST,
   input  logic pll_locked,
   output logic lock_ok
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ok_q, ok_d;

   always_comb begin
      cnt_d = cnt_q;
      ok_d  = ok_q;
      if (!pll_locked) begin
         cnt_d = '0;
         ok_d  = 1'b0;
      end else if (!ok_q) begin
         cnt_d = cnt_q + CNT_W'(1);
         ok_d  = (cnt_q == CNT_W'(LOCK_STABLE - 1));
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q <= '0;
         ok_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ok_q  <= ok_d;
      end
   end

   assign lock_ok = ok_q;

endmodule

// File: rtl/glbl_rst_seq.sv
// rtl/glbl_rst_seq.sv - lock-gated GSR/GTS/PRLD sequencer with staged per-channel resets
// GLBL_RST_SEQ_LOCK_FILTER_EN: qualify pll_locked for LOCK_STABLE cycles before use
module glbl_rst_seq
   import glbl_rst_seq_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int ROC_CYCLES  = 1000,
   parameter int TOC_CYCLES  = 0,
   parameter int STAGE_GAP   = 8,
   parameter int CNT_W       = 16,
   parameter int LOCK_STABLE = 32
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            pll_locked,
   input  logic            sw_req,
   output logic            sw_ack,
   output logic            gsr,
   output logic            gts,
   output logic            prld,
   output logic [N_CH-1:0] rst_out,
   output logic            done
);

   localparam int CNT_NEED = clog2(seq_cnt_max(ROC_CYCLES, N_CH, STAGE_GAP, LOCK_STABLE) + 1);
   localparam logic [CNT_W-1:0] TOC_LIM   = CNT_W'(TOC_CYCLES);
   localparam logic [CNT_W-1:0] ROC_LIM   = CNT_W'(ROC_CYCLES);
   localparam logic [CNT_W-1:0] STAGE_LIM = CNT_W'((N_CH - 1) * STAGE_GAP);

   if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
      $error("glbl_rst_seq: N_CH must be 1..16");
   end
   if (ROC_CYCLES < 1 || STAGE_GAP < 1 || LOCK_STABLE < 1) begin : g_bad_cycles
      $error("glbl_rst_seq: ROC_CYCLES, STAGE_GAP and LOCK_STABLE must be >= 1");
   end
   if (TOC_CYCLES < 0 || TOC_CYCLES > ROC_CYCLES) begin : g_bad_toc
      $error("glbl_rst_seq: TOC_CYCLES must be within 0..ROC_CYCLES");
   end
   if (CNT_NEED > CNT_W) begin : g_bad_cnt_w
      $error("glbl_rst_seq: CNT_W too narrow for the configured counts");
   end

   logic lock_ok;

`ifdef GLBL_RST_SEQ_LOCK_FILTER_EN
   glbl_rst_seq_lock_filter #(
      .LOCK_STABLE (LOCK_STABLE),
      .CNT_W       (CNT_W)
   ) u_lock_filter (
      .CLK        (CLK),
      .RST        (RST),
      .pll_locked (pll_locked),
      .lock_ok    (lock_ok)
   );
`else
   assign lock_ok = pll_locked;
`endif

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             gsr_q, gsr_d, gts_q, gts_d;
   logic [N_CH-1:0]  rst_out_q, rst_out_d;
   logic             done_q, done_d, sw_ack_q, sw_ack_d, sw_pending_q, sw_pending_d;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      gsr_d        = gsr_q;
      gts_d        = gts_q;
      rst_out_d    = rst_out_q;
      done_d       = done_q;
      sw_ack_d     = 1'b0;
      sw_pending_d = sw_pending_q;
      cnt_inc      = cnt_q + CNT_W'(1);

      case (state_q)
         HOLD: state_d = WAIT_LOCK;
         WAIT_LOCK: begin
            if (lock_ok) begin
               state_d = ROC;
               cnt_d   = '0;
               gts_d   = (TOC_CYCLES != 0);
            end
         end
         ROC, STAGE: begin
            if (!lock_ok) begin
               state_d   = WAIT_LOCK;
               cnt_d     = '0;
               gsr_d     = 1'b1;
               gts_d     = 1'b1;
               rst_out_d = '1;
               done_d    = 1'b0;
            end else if (state_q == ROC) begin
               cnt_d = cnt_inc;
               if (cnt_inc == TOC_LIM) gts_d = 1'b0;
               if (cnt_inc == ROC_LIM) begin
                  gsr_d        = 1'b0;
                  gts_d        = 1'b0;
                  rst_out_d[0] = 1'b0;
                  cnt_d        = '0;
                  if (N_CH == 1) begin
                     state_d      = DONE;
                     done_d       = 1'b1;
                     sw_ack_d     = sw_pending_q;
                     sw_pending_d = 1'b0;
                  end else begin
                     state_d = STAGE;
                  end
               end
            end else begin
               cnt_d = cnt_inc;
               for (int i = 1; i < N_CH; i++) begin
                  if (cnt_inc == CNT_W'(i * STAGE_GAP)) rst_out_d[i] = 1'b0;
               end
               if (cnt_inc == STAGE_LIM) begin
                  state_d      = DONE;
                  cnt_d        = '0;
                  done_d       = 1'b1;
                  sw_ack_d     = sw_pending_q;
                  sw_pending_d = 1'b0;
               end
            end
         end
         DONE: begin
            // Lock loss and a software request share one restart; the request is remembered for the ack.
            if (!lock_ok || sw_req) begin
               state_d      = WAIT_LOCK;
               cnt_d        = '0;
               gsr_d        = 1'b1;
               gts_d        = 1'b1;
               rst_out_d    = '1;
               done_d       = 1'b0;
               sw_pending_d = sw_pending_q | sw_req;
            end
         end
         default: begin
            state_d   = HOLD;
            cnt_d     = '0;
            gsr_d     = 1'b1;
            gts_d     = 1'b1;
            rst_out_d = '1;
            done_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= HOLD;
         cnt_q        <= '0;
         gsr_q        <= 1'b1;
         gts_q        <= 1'b1;
         rst_out_q    <= '1;
         done_q       <= 1'b0;
         sw_ack_q     <= 1'b0;
         sw_pending_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         gsr_q        <= gsr_d;
         gts_q        <= gts_d;
         rst_out_q    <= rst_out_d;
         done_q       <= done_d;
         sw_ack_q     <= sw_ack_d;
         sw_pending_q <= sw_pending_d;
      end
   end

   // prld shares the gsr flop so the two can never drift apart.
   assign gsr     = gsr_q;
   assign prld    = gsr_q;
   assign gts     = gts_q;
   assign rst_out = rst_out_q;
   assign done    = done_q;
   assign sw_ack  = sw_ack_q;

endmodule
